// File: rtl/i2s2_pkg.sv
// Shared types and defaults for the I2S receiver slice.
package i2s2_pkg;

  localparam int I2S2_DATA_W = 24;
  localparam int I2S2_SLOT_W = 32;

  // Receiver bit-capture states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_SKIP  = 2'd3
  } rx_state_e;

  // One buffered sample. The receiver packs FIFO entries in this same
  // {right, data} order, with the data field sized by its DATA_W parameter.
  typedef struct packed {
    logic                   right;
    logic [I2S2_DATA_W-1:0] data;
  } pcm_entry_t;

endpackage

// File: rtl/i2s2_rx_fifo.sv
// Synchronous show-ahead FIFO: rd_data always shows the oldest entry.
// A write while full is accepted only if a read happens in the same cycle.
module i2s2_rx_fifo
  import i2s2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = I2S2_DATA_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer, storage and occupancy updates for accepted writes/reads.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/i2s2_rx.sv
// I2S receiver: synchronizes the serial bus into clk, frames slots on lrclk
// changes, shifts DATA_W bits MSB first after the one-bit I2S delay and
// buffers {channel, word} in a small show-ahead FIFO.
// Handshake: an entry transfers on a clk edge where pcm_valid && pcm_ready;
// pcm_out/pcm_right hold steady while pcm_valid && !pcm_ready.
module i2s2_rx
  import i2s2_pkg::*;
#(
  parameter int DATA_W     = I2S2_DATA_W,
  parameter int SLOT_W     = I2S2_SLOT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk_in,
  input  logic              lrclk_in,
  input  logic              sdin,
  input  logic              enable,
  output logic [DATA_W-1:0] pcm_out,
  output logic              pcm_right,
  output logic              pcm_valid,
  input  logic              pcm_ready,
  output logic              overrun,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int CW = $clog2(SLOT_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_W);

  // Synchronizer chains, bit 2 = sclk, bit 1 = lrclk, bit 0 = sdin.
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       sclk_prev_q, sclk_prev_d;

  rx_state_e         state_q, state_d;
  logic              lr_prev_q, lr_prev_d;
  logic              lr_seen_q, lr_seen_d;
  logic              chan_q, chan_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_q, push_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic sclk_s, lr_s, sd_s;
  logic sclk_rise, slot_start;
  logic fifo_full, fifo_empty;
  logic frame_err_set, overrun_set;

  assign sclk_s    = sync2_q[2];
  assign lr_s      = sync2_q[1];
  assign sd_s      = sync2_q[0];
  assign sclk_rise = sclk_s && !sclk_prev_q;
  // The first sampled lrclk after reset only primes lr_prev, so a reset
  // landing mid-slot cannot fake a slot start.
  assign slot_start = sclk_rise && lr_seen_q && (lr_s != lr_prev_q);

  // Synchronizer next values.
  always_comb begin
    sync1_d     = {sclk_in, lrclk_in, sdin};
    sync2_d     = sync1_q;
    sclk_prev_d = sync2_q[2];
  end

  // FSM next state; all progress happens on detected sclk rising edges.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (sclk_rise) begin
      case (state_q)
        ST_IDLE: if (slot_start) state_d = ST_DELAY;
        ST_DELAY, ST_SHIFT: begin
          if (slot_start)              state_d = ST_DELAY;
          else if (cnt_q == LAST_BIT)  state_d = ST_SKIP;
          else                         state_d = ST_SHIFT;
        end
        ST_SKIP: if (slot_start) state_d = ST_DELAY;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: channel latch, shift register, bit counter, push strobe, flags.
  always_comb begin
    lr_prev_d     = lr_prev_q;
    lr_seen_d     = lr_seen_q;
    chan_d        = chan_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    push_d        = 1'b0;
    frame_err_set = 1'b0;
    if (sclk_rise) begin
      lr_prev_d = lr_s;
      lr_seen_d = 1'b1;
    end
    if (!enable) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sclk_rise) begin
      if (slot_start) begin
        // The bit under the slot-start edge belongs to the previous slot.
        chan_d  = lr_s;
        shift_d = '0;
        cnt_d   = '0;
        frame_err_set = (state_q == ST_DELAY) || (state_q == ST_SHIFT);
      end else if (state_q == ST_DELAY || state_q == ST_SHIFT) begin
        shift_d = DATA_W'({shift_q, sd_s});
        cnt_d   = cnt_q + 1'b1;
        push_d  = (cnt_q == LAST_BIT);
      end else if (state_q == ST_SKIP && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Sticky flags: clear on err_clr, but a same-cycle set event wins.
    overrun_set = push_q && fifo_full && !pcm_ready;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overrun_set)   overrun_d   = 1'b1;
    if (frame_err_set) frame_err_d = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Synchronizers and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      lr_seen_q   <= 1'b0;
      chan_q      <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_prev_q <= sclk_prev_d;
      lr_prev_q   <= lr_prev_d;
      lr_seen_q   <= lr_seen_d;
      chan_q      <= chan_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  i2s2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push_q),
    .wr_data ({chan_q, shift_q}),
    .rd_en   (pcm_ready),
    .rd_data ({pcm_right, pcm_out}),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pcm_valid = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s2_rx.sv
// Bench for i2s2_rx: I2S slot driver, expected-word queue checked by a
// monitor on every accepted output, plus direct flag/status checks.
`timescale 1ns/1ps
module tb_i2s2_rx;

  localparam int      DATA_W    = 24;
  localparam int      EW        = DATA_W + 1;
  localparam realtime CLK_HALF  = 5.0;
  localparam realtime SCLK_HALF = 162.76;

  logic              clk = 1'b0;
  logic              rstn;
  logic              sclk_in, lrclk_in, sdin;
  logic              enable, pcm_ready, err_clr;
  logic [DATA_W-1:0] pcm_out;
  logic              pcm_right, pcm_valid, overrun, frame_err;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  int            n_checks = 0;
  int            n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #(CLK_HALF) clk = ~clk;

  i2s2_rx dut (
    .clk       (clk),
    .rstn      (rstn),
    .sclk_in   (sclk_in),
    .lrclk_in  (lrclk_in),
    .sdin      (sdin),
    .enable    (enable),
    .pcm_out   (pcm_out),
    .pcm_right (pcm_right),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output must match the queue head.
  always @(negedge clk) begin
    if (rstn === 1'b1 && pcm_valid === 1'b1 && pcm_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got right=%0b data=%h, required no output", pcm_right, pcm_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({pcm_right, pcm_out} !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_data: got right=%0b data=%h, required right=%0b data=%h",
                   pcm_right, pcm_out, mon_exp[EW-1], mon_exp[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    pcm_ready = v;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic idle_sclk(input int n);
    for (int k = 0; k < n; k++) begin
      sclk_in = 1'b0;
      sdin    = 1'b0;
      #(SCLK_HALF);
      sclk_in = 1'b1;
      #(SCLK_HALF);
    end
  endtask

  // One I2S slot of nbits sclk periods: lrclk changes at bit 0, MSB at bit 1.
  // Bit 0 and bits past the word carry 1s so mis-framing corrupts the data.
  // At pulse_bit the rising edge is placed right after a clk falling edge and
  // pcm_ready is raised for exactly the cycle in which that word is pushed.
  task automatic drive_slot(input logic ch, input logic [DATA_W-1:0] w,
                            input int nbits, input int pulse_bit);
    for (int k = 0; k < nbits; k++) begin
      sclk_in  = 1'b0;
      lrclk_in = ch;
      sdin     = (k >= 1 && k <= DATA_W) ? w[DATA_W-k] : 1'b1;
      #(SCLK_HALF);
      if (k == pulse_bit) begin
        @(negedge clk);
        sclk_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 pcm_ready = 1'b1;
        @(posedge clk);
        #1 pcm_ready = 1'b0;
        #(SCLK_HALF);
      end else begin
        sclk_in = 1'b1;
        #(SCLK_HALF);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check({name, "_empty"}, {31'd0, pcm_valid}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(5ms);
    $display("FAIL watchdog: got no end of test, required finish within 5 ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b1; sclk_in = 1'b0; lrclk_in = 1'b1; sdin = 1'b0;
    enable = 1'b0; pcm_ready = 1'b1; err_clr = 1'b0;
    #3 rstn = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid",     {31'd0, pcm_valid}, 0);
    check("rst_out",       {8'd0, pcm_out},    0);
    check("rst_right",     {31'd0, pcm_right}, 0);
    check("rst_overrun",   {31'd0, overrun},   0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    rstn = 1'b1;
    enable = 1'b1;
    idle_sclk(4);

    // Basic frame: left then right.
    exp_q.push_back({1'b0, 24'h800001});
    exp_q.push_back({1'b1, 24'h7FFFFE});
    drive_slot(1'b0, 24'h800001, 32, -1);
    drive_slot(1'b1, 24'h7FFFFE, 32, -1);
    wait_drain("basic");
    check("basic_overrun",   {31'd0, overrun},   0);
    check("basic_frame_err", {31'd0, frame_err}, 0);

    // Consumer stalled for six words: only the first four survive.
    set_ready(1'b0);
    exp_q.push_back({1'b0, 24'h111111});
    exp_q.push_back({1'b1, 24'h222222});
    exp_q.push_back({1'b0, 24'h333333});
    exp_q.push_back({1'b1, 24'h444444});
    drive_slot(1'b0, 24'h111111, 32, -1);
    drive_slot(1'b1, 24'h222222, 32, -1);
    drive_slot(1'b0, 24'h333333, 32, -1);
    drive_slot(1'b1, 24'h444444, 32, -1);
    drive_slot(1'b0, 24'h555555, 32, -1);
    drive_slot(1'b1, 24'h666666, 32, -1);
    @(negedge clk);
    check("ovr_set",        {31'd0, overrun},   1);
    check("ovr_valid",      {31'd0, pcm_valid}, 1);
    check("ovr_head_held",  {8'd0, pcm_out},    32'h111111);
    set_ready(1'b1);
    wait_drain("ovr");
    pulse_err_clr();
    @(negedge clk);
    check("ovr_cleared",    {31'd0, overrun},   0);
    check("ovr_no_frame_err", {31'd0, frame_err}, 0);

    // Enable raised mid-slot: first word comes from the next full slot.
    enable = 1'b0;
    exp_q.push_back({1'b1, 24'h13579B});
    fork
      drive_slot(1'b0, 24'hDEAD00, 32, -1);
      begin
        #(24.0 * SCLK_HALF);
        enable = 1'b1;
      end
    join
    drive_slot(1'b1, 24'h13579B, 32, -1);
    wait_drain("en_mid");
    check("en_mid_frame_err", {31'd0, frame_err}, 0);

    // Short slot: lrclk flips after 10 data bits.
    exp_q.push_back({1'b1, 24'h123456});
    drive_slot(1'b0, 24'hABCDEF, 11, -1);
    drive_slot(1'b1, 24'h123456, 32, -1);
    wait_drain("short");
    check("short_frame_err", {31'd0, frame_err}, 1);
    check("short_overrun",   {31'd0, overrun},   0);
    pulse_err_clr();
    @(negedge clk);
    check("short_err_cleared", {31'd0, frame_err}, 0);

    // Reset mid-word with two words buffered.
    set_ready(1'b0);
    drive_slot(1'b0, 24'h0F0F0F, 32, -1);
    drive_slot(1'b1, 24'hF0F0F0, 32, -1);
    @(negedge clk);
    check("rstmid_before_valid", {31'd0, pcm_valid}, 1);
    fork
      drive_slot(1'b0, 24'h5A5A5A, 32, -1);
      begin
        #(24.0 * SCLK_HALF);
        rstn = 1'b0;
        #30;
        check("rstmid_valid", {31'd0, pcm_valid}, 0);
        check("rstmid_out",   {8'd0, pcm_out},    0);
        rstn = 1'b1;
      end
    join
    set_ready(1'b1);
    exp_q.push_back({1'b1, 24'hC3C3C3});
    drive_slot(1'b1, 24'hC3C3C3, 32, -1);
    wait_drain("rstmid");
    check("rstmid_overrun",   {31'd0, overrun},   0);
    check("rstmid_frame_err", {31'd0, frame_err}, 0);

    // Full FIFO with a pop in the very cycle of the push.
    set_ready(1'b0);
    exp_q.push_back({1'b0, 24'hA00001});
    exp_q.push_back({1'b1, 24'hB00002});
    exp_q.push_back({1'b0, 24'hC00003});
    exp_q.push_back({1'b1, 24'hD00004});
    exp_q.push_back({1'b0, 24'hE00005});
    drive_slot(1'b1, 24'h000000, 2, -1);
    drive_slot(1'b0, 24'hA00001, 32, -1);
    drive_slot(1'b1, 24'hB00002, 32, -1);
    drive_slot(1'b0, 24'hC00003, 32, -1);
    drive_slot(1'b1, 24'hD00004, 32, -1);
    drive_slot(1'b0, 24'hE00005, 32, DATA_W);
    @(negedge clk);
    check("fullpop_overrun", {31'd0, overrun},   0);
    check("fullpop_valid",   {31'd0, pcm_valid}, 1);
    check("fullpop_left",    exp_q.size(),       4);
    set_ready(1'b1);
    wait_drain("fullpop");
    check("fullpop_overrun_end", {31'd0, overrun}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s2_rx.md
I2S2_RX -- requirements
Module: i2s2_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24: PCM sample width.
REQ-002 SHALL have parameter SLOT_W, default 32: sclk periods per channel slot.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, power of two.
REQ-004 SHALL have ports, one per line:
- clk  in  1  system clock; reset rstn, asynchronous, active-low; clock clk
- rstn  in  1  asynchronous active-low reset
- sclk_in  in  1  I2S serial clock from ADC/master, asynchronous to clk
- lrclk_in  in  1  I2S word clock; 0 = left, 1 = right
- sdin  in  1  I2S serial data from ADC
- enable  in  1  capture enable
- pcm_out  out  DATA_W  received sample, two's complement
- pcm_right  out  1  channel tag of pcm_out; 1 = right
- pcm_valid  out  1  pcm_out/pcm_right hold a valid entry
- pcm_ready  in  1  consumer accepts entry when pcm_valid && pcm_ready
- overrun  out  1  sticky: a word was dropped because the FIFO was full
- frame_err  out  1  sticky: a slot ended before DATA_W bits were captured
- err_clr  in  1  clears overrun and frame_err

Function
REQ-005 SHALL pass sclk_in, lrclk_in and sdin each through a 2-flop synchronizer; clk frequency SHALL be >= 4x sclk.
REQ-006 SHALL detect a sclk rising edge as synced sclk 0 in the previous cycle and 1 in the current cycle; all sampling SHALL occur only on that cycle.
REQ-007 SHALL sample synced lrclk and sdin together on each sclk rising edge; an lrclk change between consecutive samples SHALL mark a slot start.
REQ-008 SHALL follow I2S one-bit delay: the sdin bit sampled at the slot-start edge SHALL be discarded; the next DATA_W bits SHALL be shifted in MSB first.
REQ-009 SHALL implement FSM states IDLE, DELAY, SHIFT, SKIP:
- IDLE -> DELAY at a slot start while enable = 1
- DELAY -> SHIFT at the next sclk rising edge, which captures bit DATA_W-1
- SHIFT -> SKIP after DATA_W bits are captured, and the word is pushed
- SKIP -> DELAY at the next slot start
- any state -> IDLE when enable = 0
REQ-010 SHALL latch the channel tag as the new lrclk value at slot start.
REQ-011 SHALL push {channel, word} into the FIFO in the clk cycle after the sclk edge that captured the LSB; pcm_valid SHALL rise in the cycle after the push (show-ahead FIFO).
REQ-012 SHALL pop the FIFO on pcm_valid && pcm_ready; pcm_out SHALL remain stable while pcm_valid && !pcm_ready.
REQ-013 Push while full with no pop in the same cycle: word dropped, FIFO unchanged, overrun set. Simultaneous push and pop while full: both SHALL occur, overrun not set.
REQ-014 Slot start in SHIFT: partial word discarded, frame_err set, FSM -> DELAY for the new slot.
REQ-015 After reset or enable rising, SHALL capture nothing until the first slot start, so no partial first word is delivered.
REQ-016 enable = 0 SHALL discard the in-progress word; FIFO contents SHALL be retained and drainable.
REQ-017 err_clr SHALL clear the sticky flags the next cycle; a same-cycle set event SHALL win.
REQ-018 SHALL count bits with a counter wide enough for SLOT_W; bits beyond DATA_W in a slot SHALL be ignored.

Reset
REQ-019 On rstn low: synchronizers 0, FSM IDLE, FIFO empty, pcm_valid 0, pcm_out 0, pcm_right 0, overrun 0, frame_err 0, shift register and counter 0.
REQ-020 Reset mid-word SHALL discard the word; after release, REQ-015 SHALL apply.

Structure
REQ-021 Package i2s2_pkg SHALL hold DATA_W/SLOT_W defaults, the FSM state enum, and the FIFO entry struct {right, data}.
REQ-022 The FIFO SHALL be a sub-module i2s2_rx_fifo (synchronous, show-ahead, full/empty, DEPTH parameter); all other logic SHALL be in i2s2_rx.

Verification
REQ-023 clk 100 MHz, sclk 3.072 MHz, 64-sclk frames; left 24'h800001, right 24'h7FFFFE -> pcm_out sequence 800001/right=0, then 7FFFFE/right=1, no flags.
REQ-024 pcm_ready held 0 for 6 words -> 4 entries kept, overrun = 1, the first 4 words read back in order; err_clr -> overrun = 0.
REQ-025 Enable raised mid-slot -> first delivered word comes from the next complete slot.
REQ-026 lrclk toggled after 10 data bits -> frame_err = 1, no word pushed; next full slot delivered correctly.
REQ-027 rstn pulsed low mid-SHIFT with 2 words in FIFO -> pcm_valid = 0, FIFO empty, next word is first full slot after release.
REQ-028 FIFO full with pcm_ready = 1 in the same cycle as a push -> no overrun, count stays 4.
